in_ram_reader: RTL and testbench

Streaming fetch controller directly downstream of the input RAM (registered-read, one-cycle latency, output cleared on reset). On a start pulse it walks a contiguous address window, drives the RAM address and captures each returned word. It delivers the words in order on a valid/ready stream to the processing datapath, absorbing consumer backpressure without losing or duplicating words.

---
 rtl/in_ram_reader.sv | 188 ++++++++++++++++++
 tb/tb_in_ram_reader.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/in_ram_reader.sv
// in_ram_reader: walks a contiguous window of a registered-read RAM and streams
// the returned words in address order on a valid/ready interface, with a
// 2-entry buffer that absorbs consumer backpressure.
// Optional feature: define IN_READER_LAST_EN to add out_last, which marks the
// final word of a transfer.
module in_ram_reader #(
  parameter int unsigned ADDR_WIDTH = 16,
  parameter int unsigned DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] base_addr,
  input  logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  input  logic [DATA_WIDTH-1:0] mem_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  busy,
  output logic                  done
`ifdef IN_READER_LAST_EN
  ,
  output logic                  out_last
`endif
);

  localparam int unsigned CNT_WIDTH = ADDR_WIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_WIDTH-1:0]   remaining;
  logic                   inflight;
  logic                   skid_valid;
  logic [DATA_WIDTH-1:0]  skid_data;

  logic                   issue;
  logic                   load;
  logic                   push;
  logic                   pop;
  logic [1:0]             occ;
  logic [1:0]             occ_next;
  logic                   room;
  logic                   head_from_skid;
  logic                   head_from_mem;
  logic                   skid_from_mem;

  // Buffer occupancy bookkeeping and the issue-credit rule.
  always_comb begin
    push           = inflight;
    pop            = out_valid && out_ready;
    occ            = 2'(out_valid) + 2'(skid_valid);
    occ_next       = occ + 2'(push) - 2'(pop);
    room           = (3'(occ) + 3'(inflight)) <= (3'd1 + 3'(pop));
    head_from_skid = pop && skid_valid;
    head_from_mem  = push && (pop ? !skid_valid : !out_valid);
    skid_from_mem  = push && (pop ? skid_valid : out_valid);
  end

  // Next-state and issue/load decode.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    load       = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (count != '0) begin
            load       = 1'b1;
            state_next = ISSUE;
          end else begin
            state_next = DONE;
          end
        end
      end
      ISSUE: begin
        if (remaining == '0) begin
          state_next = DRAIN;
        end else begin
          issue = room;
        end
      end
      DRAIN: begin
        // Leave as the last word is taken so done lands right after it.
        if (!inflight && (occ == 2'd0 || (occ == 2'd1 && pop))) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State register with registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_next;
      busy  <= (state_next != IDLE);
      done  <= (state_next == DONE);
    end
  end

  // Address walk and in-flight tracking.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem_addr  <= '0;
      remaining <= '0;
      inflight  <= 1'b0;
    end else begin
      if (load) begin
        mem_addr  <= base_addr;
        remaining <= count;
      end else if (issue) begin
        mem_addr  <= mem_addr + ADDR_WIDTH'(1);
        remaining <= remaining - CNT_WIDTH'(1);
      end
      inflight <= issue;
    end
  end

  // Two-entry output buffer: head drives out_data, skid holds the overflow word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_data   <= '0;
      skid_valid <= 1'b0;
      skid_data  <= '0;
    end else begin
      out_valid  <= (occ_next != 2'd0);
      skid_valid <= (occ_next == 2'd2);
      if (head_from_skid) begin
        out_data <= skid_data;
      end else if (head_from_mem) begin
        out_data <= mem_data;
      end
      if (skid_from_mem) begin
        skid_data <= mem_data;
      end
    end
  end

`ifdef IN_READER_LAST_EN
  logic inflight_last;
  logic head_last;
  logic skid_last;

  // Last-word flag travels alongside each word through the buffer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inflight_last <= 1'b0;
      head_last     <= 1'b0;
      skid_last     <= 1'b0;
    end else begin
      inflight_last <= issue && (remaining == CNT_WIDTH'(1));
      if (head_from_skid) begin
        head_last <= skid_last;
      end else if (head_from_mem) begin
        head_last <= inflight_last;
      end else if (pop) begin
        head_last <= 1'b0;
      end
      if (skid_from_mem) begin
        skid_last <= inflight_last;
      end else if (head_from_skid) begin
        skid_last <= 1'b0;
      end
    end
  end

  assign out_last = head_last;
`endif

endmodule

// File: tb/tb_in_ram_reader.sv
// Testbench for in_ram_reader: registered-read RAM model, table of transfers,
// scoreboard of expected words checked as the consumer accepts them, plus a
// mid-transfer reset sequence. Define IN_READER_LAST_EN to also check out_last.
module tb_in_ram_reader;

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  logic          clk;
  logic          rst;
  logic          start;
  logic [AW-1:0] base_addr;
  logic [AW:0]   count;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_data;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic          busy;
  logic          done;
`ifdef IN_READER_LAST_EN
  logic          out_last;
`endif

  in_ram_reader #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .base_addr (base_addr),
    .count     (count),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .done      (done)
`ifdef IN_READER_LAST_EN
    ,
    .out_last  (out_last)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // RAM contents: mem[i] = i + 0x100, registered read, output cleared on reset.
  logic [DW-1:0] mem [0:65535];
  initial begin
    for (int i = 0; i < 65536; i++) mem[i] = 16'(i + 32'h100);
  end

  always @(posedge clk or posedge rst) begin
    if (rst) mem_data <= '0;
    else     mem_data <= mem[mem_addr];
  end

  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } exp_t;

  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  int   words_seen = 0;
  bit   mon_en = 1'b0;
  int   ready_mode = 0;
  int   pat_idx = 0;
  bit   prev_stall = 1'b0;
  logic [DW-1:0] prev_data = '0;
  logic [AW-1:0] exp_addr = '0;

  task automatic check(input bit ok, input string name,
                       input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (ok) passes++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
  endtask

  // Consumer ready: 0 = always, 1 = pattern 1,0,0,1,0,..., 2 = random.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      0:       out_ready = 1'b1;
      1:       out_ready = ((pat_idx % 5) == 0) || ((pat_idx % 5) == 3);
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    pat_idx++;
  end

  // Monitor: compare accepted words against the scoreboard, check stall hold.
  always @(negedge clk) begin
    if (mon_en && !rst) begin
      if (prev_stall)
        check(out_valid && (out_data == prev_data), "stall_hold", 32'(out_data), 32'(prev_data));
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          check(1'b0, "spurious_word", 32'(out_data), 32'h0);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          check(out_data == e.data, "word", 32'(out_data), 32'(e.data));
`ifdef IN_READER_LAST_EN
          check(out_last == e.last, "out_last", 32'(out_last), 32'(e.last));
`endif
          words_seen++;
        end
      end
`ifdef IN_READER_LAST_EN
      if (out_last && !out_valid) check(1'b0, "last_without_valid", 32'(out_last), 32'h0);
`endif
      prev_stall = out_valid && !out_ready;
      prev_data  = out_data;
    end else begin
      prev_stall = 1'b0;
    end
  end

  // One transfer: start, wait bounded for done, check latency/counts/address.
  task automatic run_xfer(input logic [AW-1:0] b, input logic [AW:0] c,
                          input int mode, input int exp_done);
    int lat;
    int first_v;
    bit any_valid;
    ready_mode = mode;
    @(posedge clk);
    #1;
    words_seen = 0;
    base_addr  = b;
    count      = c;
    start      = 1'b1;
    for (int i = 0; i < int'(c); i++) begin
      exp_t e;
      e.data = mem[16'(b + 16'(i))];
      e.last = (i == int'(c) - 1);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start     = 1'b0;
    lat       = 0;
    first_v   = -1;
    any_valid = out_valid;
    if (out_valid) first_v = 0;
    while (!done && lat < 400) begin
      @(posedge clk);
      #1;
      lat++;
      if (out_valid) begin
        any_valid = 1'b1;
        if (first_v < 0) first_v = lat;
      end
    end
    if (!done) check(1'b0, "done_timeout", 32'(lat), 32'(exp_done));
    if (exp_done >= 0) check(lat == exp_done, "done_latency", 32'(lat), 32'(exp_done));
    if (c != '0 && mode == 0) check(first_v == 2, "first_valid_latency", 32'(first_v), 32'd2);
    if (c == '0) check(!any_valid, "no_valid_on_zero", 32'(any_valid), 32'h0);
    check(words_seen == int'(c), "word_count", 32'(words_seen), 32'(c));
    check(sbq.size() == 0, "scoreboard_empty", 32'(sbq.size()), 32'h0);
    if (c != '0) exp_addr = 16'(b + 16'(c));
    check(mem_addr == exp_addr, "mem_addr_final", 32'(mem_addr), 32'(exp_addr));
    @(posedge clk);
    #1;
    check(!done, "done_one_cycle", 32'(done), 32'h0);
    check(!busy, "busy_cleared", 32'(busy), 32'h0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check(busy == 1'b0,      {tag, "_busy"},      32'(busy), 32'h0);
    check(done == 1'b0,      {tag, "_done"},      32'(done), 32'h0);
    check(out_valid == 1'b0, {tag, "_out_valid"}, 32'(out_valid), 32'h0);
    check(out_data == '0,    {tag, "_out_data"},  32'(out_data), 32'h0);
    check(mem_addr == '0,    {tag, "_mem_addr"},  32'(mem_addr), 32'h0);
`ifdef IN_READER_LAST_EN
    check(out_last == 1'b0,  {tag, "_out_last"},  32'(out_last), 32'h0);
`endif
  endtask

  typedef struct {
    logic [AW-1:0] base;
    logic [AW:0]   cnt;
    int            mode;
    int            exp_done;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int n;
    vecs[0] = '{16'h0004, 17'd8, 0, 10};
    vecs[1] = '{16'h0004, 17'd8, 1, -1};
    vecs[2] = '{16'hFFFE, 17'd4, 0, 6};
    vecs[3] = '{16'h1234, 17'd0, 0, 0};
    vecs[4] = '{16'h0010, 17'd5, 2, -1};
    vecs[5] = '{16'hFFFF, 17'd1, 1, -1};
    vecs[6] = '{16'h0020, 17'd3, 0, 5};

    rst       = 1'b1;
    start     = 1'b0;
    base_addr = '0;
    count     = '0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;

    for (int v = 0; v < 7; v++)
      run_xfer(vecs[v].base, vecs[v].cnt, vecs[v].mode, vecs[v].exp_done);

    // Reset in the middle of a transfer, after three words are accepted.
    ready_mode = 0;
    @(posedge clk);
    #1;
    words_seen = 0;
    base_addr  = 16'h0004;
    count      = 17'd8;
    start      = 1'b1;
    for (int i = 0; i < 8; i++) begin
      exp_t e;
      e.data = mem[16'(16'h0004 + 16'(i))];
      e.last = (i == 7);
      sbq.push_back(e);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    n = 0;
    while (words_seen < 3 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check(words_seen == 3, "mid_reset_reached", 32'(words_seen), 32'd3);
    #2;
    rst = 1'b1;
    #1;
    check_reset_outputs("mid_reset");
    mon_en = 1'b0;
    sbq.delete();
    exp_addr = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst    = 1'b0;
    mon_en = 1'b1;
    run_xfer(16'h0000, 17'd2, 0, 4);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
